move_sequencer: RTL
===================

// Module: move_sequencer
// PURPOSE
//   Builds the two 9-bit board vectors (xin_star/oin_star) from a stream of player
//   moves, alternates turns X/O, and rejects illegal moves before they are committed.
//   Board vectors feed the combinational Status checker. Its win/lose/draw flags are
//   sampled back one cycle later to end the game.
//   Bit k of each vector = cell k, row-major (0 top-left .. 8 bottom-right).
// PARAMETERS
//   FIRST_O       0   1 = O moves first after reset/new_game, 0 = X first
//   TURN_TIMEOUT  0   cycles a player may idle before forfeiting the turn; 0 = disabled
// PORTS
//   clk           in   1  single clock, all state on rising edge
//   reset         in   1  synchronous, active-high
//   new_game      in   1  synchronous clear to start-of-game, any state
//   move_valid    in   1  move request, qualified by move_ready
//   move_pos      in   4  target cell 0..8
//   win_game      in   1  from Status: X has three in a row
//   lose_game     in   1  from Status: O has three in a row
//   draw_game     in   1  from Status: board full
//   xin_star      out  9  registered X occupancy
//   oin_star      out  9  registered O occupancy
//   turn_o        out  1  1 = O to move, 0 = X to move
//   move_ready    out  1  high in X_TURN/O_TURN only
//   move_ack      out  1  1-cycle pulse, move committed
//   move_nack     out  1  1-cycle pulse, move rejected
//   timeout_pulse out  1  1-cycle pulse, turn forfeited
//   move_count    out  4  committed moves, 0..9
//   result        out  2  00 none, 01 X win, 10 O win, 11 draw
//   game_over     out  1  high in OVER state
// BEHAVIOUR
//   - States: X_TURN, O_TURN, CHECK, OVER. Registered outputs; move_ready/turn_o/game_over decode state.
//   - Reset/new_game: boards=0, move_count=0, result=00, pulses=0, timer=0.
//     State goes to X_TURN, or O_TURN if FIRST_O=1. new_game wins over move_valid in the same cycle.
//   - Legal move: state is X_TURN/O_TURN, move_valid=1, move_pos<=8, and the cell is clear in both vectors.
//     At edge N the mover's bit is set and move_count increments. move_ack is high in cycle N+1.
//     The next state is CHECK, and the mover is remembered.
//   - Illegal move (occupied cell or pos 9..15) in a turn state: no state change.
//     move_nack is high in the next cycle. The timer keeps running.
//   - move_valid while move_ready=0 (CHECK/OVER) is ignored silently, with no ack or nack.
//   - CHECK (exactly 1 cycle) samples the status inputs, which are driven from the registered boards.
//     Priority: win_game -> result=01 -> OVER; else lose_game -> 10 -> OVER;
//     else draw_game -> 11 -> OVER; else enter the other player's turn state.
//   - Move latency: request at edge N, boards updated after N, ack during N+1, next move_ready from cycle N+2.
//   - Timer: cleared on entry to a turn state and on any accepted move. Increments each cycle in a turn state.
//     On reaching TURN_TIMEOUT with no accepted move, the turn passes to the other player.
//     timeout_pulse is high the next cycle. Boards and move_count are unchanged.
//     If a legal move arrives in the expiry cycle, the move wins and there is no timeout.
//   - OVER holds boards/result/move_count until reset or new_game.
//   - move_count never exceeds 9: a 9th legal move always fills the board and CHECK exits to OVER.
// TESTING
//   1. Reset, FIRST_O=0 -> xin=0, oin=0, turn_o=0, move_ready=1, count=0, result=00, no pulses.
//   2. X4,O0,X2,O8,X6 -> ack on each move. After the final CHECK: xin=9'h054, oin=9'h101, result=01, game_over=1, count=5.
//   3. X4 then O requests 4 -> nack, oin=0, turn_o stays 1. Then O requests pos 9 and pos 15 -> nack both times.
//   4. X0,O1,X2,O4,X3,O5,X7,O6,X8 -> result=11, count=9, xin=9'h18D, oin=9'h072.
//   5. TURN_TIMEOUT=8, X idles 8 cycles -> timeout_pulse once, turn_o=1, boards=0, count=0.
//   6. Mid-game, new_game and a legal move_valid together -> boards=0, count=0, X_TURN, no ack.
//      Also: move_valid during CHECK/OVER -> no ack or nack.

Source files
------------

// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : move_sequencer
// Description : Tic-tac-toe move sequencer. Builds the X/O board vectors from
//               a stream of move requests, alternates turns, rejects illegal
//               moves, samples the external status checker after every move
//               and optionally forfeits idle turns.
// Revision    : 1.0 - initial release
// ============================================================================
module move_sequencer #(
  parameter bit FIRST_O      = 1'b0,
  parameter int TURN_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  input  logic       win_game,
  input  logic       lose_game,
  input  logic       draw_game,
  output logic [8:0] xin_star,
  output logic [8:0] oin_star,
  output logic       turn_o,
  output logic       move_ready,
  output logic       move_ack,
  output logic       move_nack,
  output logic       timeout_pulse,
  output logic [3:0] move_count,
  output logic [1:0] result,
  output logic       game_over
);

  typedef enum logic [1:0] {
    X_TURN = 2'd0,
    O_TURN = 2'd1,
    CHECK  = 2'd2,
    OVER   = 2'd3
  } state_t;

  // Timer is wide enough to hold TURN_TIMEOUT; one extra bit for the compare.
  localparam int          TW      = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT + 1) : 1;
  localparam logic [TW:0] C_LIMIT = (TW + 1)'(TURN_TIMEOUT);
  localparam state_t      C_START = FIRST_O ? O_TURN : X_TURN;

  state_t        state_q, state_d;
  logic [8:0]    xin_q, xin_d;
  logic [8:0]    oin_q, oin_d;
  logic [3:0]    count_q, count_d;
  logic [1:0]    result_q, result_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          to_q, to_d;
  logic          mover_o_q, mover_o_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          w_in_turn;
  logic          w_cur_o;
  logic [15:0]   w_occ_ext;
  logic          w_legal;
  logic [8:0]    w_bit;
  logic [TW:0]   w_timer_next;
  logic          w_expire;

  // Legality of the current request and turn-timer expiry
  always_comb begin
    w_in_turn    = (state_q == X_TURN) || (state_q == O_TURN);
    w_cur_o      = (state_q == O_TURN);
    w_occ_ext    = {7'd0, xin_q | oin_q};
    w_legal      = w_in_turn && move_valid && (move_pos <= 4'd8) && !w_occ_ext[move_pos];
    w_bit        = 9'd1 << move_pos;
    w_timer_next = {1'b0, timer_q} + (TW + 1)'(1);
    w_expire     = (TURN_TIMEOUT != 0) && w_in_turn && (w_timer_next == C_LIMIT);
  end

  // Next-state logic for the sequencer FSM and all its registered outputs
  always_comb begin
    state_d   = state_q;
    xin_d     = xin_q;
    oin_d     = oin_q;
    count_d   = count_q;
    result_d  = result_q;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    to_d      = 1'b0;
    mover_o_d = mover_o_q;
    timer_d   = timer_q;

    case (state_q)
      X_TURN, O_TURN: begin
        if (TURN_TIMEOUT != 0) begin
          timer_d = w_timer_next[TW-1:0];
        end
        if (w_legal) begin
          // A legal move in the expiry cycle takes precedence over the forfeit.
          if (w_cur_o) begin
            oin_d = oin_q | w_bit;
          end else begin
            xin_d = xin_q | w_bit;
          end
          count_d   = count_q + 4'd1;
          ack_d     = 1'b1;
          mover_o_d = w_cur_o;
          timer_d   = '0;
          state_d   = CHECK;
        end else begin
          if (move_valid) begin
            nack_d = 1'b1;
          end
          if (w_expire) begin
            to_d    = 1'b1;
            timer_d = '0;
            state_d = w_cur_o ? X_TURN : O_TURN;
          end
        end
      end
      CHECK: begin
        // Status inputs now reflect the boards updated by the last move.
        timer_d = '0;
        if (win_game) begin
          result_d = 2'b01;
          state_d  = OVER;
        end else if (lose_game) begin
          result_d = 2'b10;
          state_d  = OVER;
        end else if (draw_game) begin
          result_d = 2'b11;
          state_d  = OVER;
        end else begin
          state_d = mover_o_q ? X_TURN : O_TURN;
        end
      end
      default: begin
        // OVER holds everything until reset or new_game.
      end
    endcase

    // new_game overrides anything requested in the same cycle.
    if (new_game) begin
      state_d   = C_START;
      xin_d     = '0;
      oin_d     = '0;
      count_d   = '0;
      result_d  = '0;
      ack_d     = 1'b0;
      nack_d    = 1'b0;
      to_d      = 1'b0;
      mover_o_d = 1'b0;
      timer_d   = '0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= C_START;
      xin_q     <= '0;
      oin_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      to_q      <= 1'b0;
      mover_o_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      xin_q     <= xin_d;
      oin_q     <= oin_d;
      count_q   <= count_d;
      result_q  <= result_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      to_q      <= to_d;
      mover_o_q <= mover_o_d;
      timer_q   <= timer_d;
    end
  end

  assign xin_star      = xin_q;
  assign oin_star      = oin_q;
  assign move_count    = count_q;
  assign result        = result_q;
  assign move_ack      = ack_q;
  assign move_nack     = nack_q;
  assign timeout_pulse = to_q;
  assign turn_o        = (state_q == O_TURN);
  assign move_ready    = (state_q == X_TURN) || (state_q == O_TURN);
  assign game_over     = (state_q == OVER);

endmodule
`default_nettype wire
